// File: rtl/sa_dma_pkg.sv
// Shared definitions for the systolic-array DMA read path: default word/row
// geometry and the row-assembler output-stage state type.
package sa_dma_pkg;

  localparam int SA_DATA_W    = 32;
  localparam int SA_ROW_WORDS = 4;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers, an explicit occupancy counter
// and a synchronous clear. A write while full is accepted only alongside a pop.
module sa_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   i_clear,
  input  logic                   i_wr,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_rd,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_pop     = i_rd & ~o_empty;
  assign w_push    = i_wr & (~o_full | w_pop);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // NOTE: storage is deliberately left out of reset; the pointers and level
  // decide what is valid, and a resettable array costs a mux per bit.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: all state registers use non-blocking assignments so every block
  // sees pre-edge values regardless of evaluation order.
  always_ff @(posedge ACLK) begin
    if (ARESET || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rd_row_assembler.sv
// Packs the DMA read word stream into ROW_WORDS-wide rows for the systolic
// array, buffered by an input FIFO and a one-row output register.
module rd_row_assembler
  import sa_dma_pkg::*;
#(
  parameter int DATA_W     = SA_DATA_W,
  parameter int ROW_WORDS  = SA_ROW_WORDS,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        i_clear,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_valid,
  output logic [ROW_WORDS*DATA_W-1:0] o_row,
  output logic                        o_row_valid,
  input  logic                        i_row_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  output logic                        o_partial
);

  localparam int                CNT_W     = $clog2(ROW_WORDS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ROW_WORDS - 1);

  out_state_e                       r_state;
  logic [CNT_W-1:0]                 r_asm_cnt;
  logic [ROW_WORDS-1:0][DATA_W-1:0] r_asm;
  logic [ROW_WORDS-1:0][DATA_W-1:0] r_row;
  logic [ROW_WORDS-1:0][DATA_W-1:0] w_row_done;
  logic                             r_overflow;
  logic [DATA_W-1:0]                w_pop_data;
  logic w_full, w_empty, w_last, w_stall, w_pop, w_complete, w_handshake, w_drop;

  sa_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .i_clear   (i_clear),
    .i_wr      (i_valid),
    .i_wr_data (i_data),
    .i_rd      (w_pop),
    .o_rd_data (w_pop_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (o_level)
  );

  assign o_row_valid = (r_state == OUT_FULL);
  assign w_last      = (r_asm_cnt == LAST_SLOT);
  assign w_handshake = o_row_valid & i_row_ready;
  // Only the row-completing pop must wait for the output register to free up.
  assign w_stall     = w_last & o_row_valid & ~i_row_ready;
  assign w_pop       = ~w_empty & ~w_stall;
  assign w_complete  = w_pop & w_last;
  assign w_drop      = i_valid & w_full & ~w_pop;

  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_row_done                = r_asm;
    w_row_done[ROW_WORDS-1]   = w_pop_data;
  end

  always_ff @(posedge ACLK) begin
    if (w_pop) r_asm[r_asm_cnt] <= w_pop_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)          r_row <= '0;
    else if (w_complete && !i_clear) r_row <= w_row_done;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || i_clear) begin
      r_state    <= OUT_EMPTY;
      r_asm_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) r_asm_cnt <= w_last ? '0 : r_asm_cnt + 1'b1;
      if (w_complete)       r_state <= OUT_FULL;
      else if (w_handshake) r_state <= OUT_EMPTY;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_row      = r_row;
  assign o_overflow = r_overflow;
  assign o_partial  = (r_asm_cnt != '0);

endmodule

// File: tb/tb_rd_row_assembler.sv
// Self-checking bench for rd_row_assembler: directed scenarios plus a random
// stream, checked against a queue-based model of the buffering rules.
module tb_rd_row_assembler;

  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int DEPTH = 16;

  logic              ACLK = 1'b0;
  logic              ARESET, i_clear, i_valid, i_row_ready;
  logic [DW-1:0]     i_data;
  logic [RW*DW-1:0]  o_row;
  logic              o_row_valid, o_overflow, o_partial;
  logic [4:0]        o_level;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0]    m_fifo[$];
  logic [DW-1:0]    m_asm[$];
  logic             m_valid = 1'b0;
  logic             m_ovf   = 1'b0;
  logic [RW*DW-1:0] m_row   = '0;
  logic [RW*DW-1:0] rx_rows[$];

  rd_row_assembler #(.DATA_W(DW), .ROW_WORDS(RW), .FIFO_DEPTH(DEPTH)) u_dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .i_clear     (i_clear),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_row       (o_row),
    .o_row_valid (o_row_valid),
    .i_row_ready (i_row_ready),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .o_partial   (o_partial)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [RW*DW-1:0] pack(input logic [DW-1:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Drive one cycle, log any handshake, advance the model, sample after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic clr, input logic rst);
    logic full, stall, pop;
    logic [DW-1:0] w;
    ARESET = rst; i_clear = clr; i_valid = v; i_data = d; i_row_ready = rdy;
    if (!rst && !clr && o_row_valid === 1'b1 && rdy) rx_rows.push_back(o_row);
    if (rst || clr) begin
      m_fifo.delete(); m_asm.delete(); m_valid = 1'b0; m_ovf = 1'b0;
      if (rst) m_row = '0;
    end else begin
      full  = (m_fifo.size() == DEPTH);
      stall = (m_asm.size() == RW - 1) && m_valid && !rdy;
      pop   = (m_fifo.size() != 0) && !stall;
      if (pop) begin w = m_fifo.pop_front(); m_asm.push_back(w); end
      if (v) begin
        if (!full || pop) m_fifo.push_back(d);
        else m_ovf = 1'b1;
      end
      if (m_asm.size() == RW) begin
        for (int i = 0; i < RW; i++) m_row[i*DW +: DW] = m_asm[i];
        m_asm.delete();
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n_total++; if (o_row !== '0)       begin n_bad++; $display("FAIL reset_row got=%h want=0", o_row); end
    n_total++; if (o_row_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", o_row_valid); end
    n_total++; if (o_level !== 5'd0)   begin n_bad++; $display("FAIL reset_level got=%0d want=0", o_level); end
    n_total++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", o_overflow); end
    n_total++; if (o_partial !== 1'b0) begin n_bad++; $display("FAIL reset_partial got=%b want=0", o_partial); end
  endtask

  task automatic test_stream();
    step(0, 0, 1, 1, 0);
    rx_rows.delete();
    for (int i = 0; i < 4; i++) step(1, DW'(i), 1, 0, 0);
    n_total++; if (o_row_valid !== 1'b0) begin n_bad++; $display("FAIL stream_lat_n1 got=%b want=0", o_row_valid); end
    step(1, 32'd4, 1, 0, 0);
    n_total++; if (o_row_valid !== 1'b1) begin n_bad++; $display("FAIL stream_lat_n2 got=%b want=1", o_row_valid); end
    n_total++; if (o_row !== pack(32'd0)) begin n_bad++; $display("FAIL stream_row0 got=%h want=%h", o_row, pack(32'd0)); end
    for (int i = 5; i < 8; i++) step(1, DW'(i), 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    n_total++; if (rx_rows.size() != 2) begin n_bad++; $display("FAIL stream_count got=%0d want=2", rx_rows.size()); end
    if (rx_rows.size() >= 2) begin
      n_total++; if (rx_rows[0] !== pack(32'd0)) begin n_bad++; $display("FAIL stream_rx0 got=%h want=%h", rx_rows[0], pack(32'd0)); end
      n_total++; if (rx_rows[1] !== pack(32'd4)) begin n_bad++; $display("FAIL stream_rx1 got=%h want=%h", rx_rows[1], pack(32'd4)); end
    end
    n_total++; if (o_level !== 5'd0) begin n_bad++; $display("FAIL stream_level got=%0d want=0", o_level); end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1, 0);
    // 4 words sit in the output row and 3 in the assembler, so 23 fill the FIFO.
    for (int i = 0; i < 26; i++) begin
      step(1, 32'h100 + DW'(i), 0, 0, 0);
      if (o_row_valid === 1'b1) begin
        n_total++; if (o_row !== pack(32'h100)) begin n_bad++; $display("FAIL ovf_row_hold got=%h want=%h", o_row, pack(32'h100)); end
      end
    end
    n_total++; if (o_level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got=%0d want=16", o_level); end
    n_total++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", o_overflow); end
    n_total++; if (o_row_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got=%b want=1", o_row_valid); end
    n_total++; if (o_level !== 5'(m_fifo.size())) begin n_bad++; $display("FAIL ovf_model_level got=%0d want=%0d", o_level, m_fifo.size()); end
  endtask

  task automatic test_clear();
    step(0, 0, 1, 1, 0);
    n_total++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got=%b want=0", o_overflow); end
    n_total++; if (o_level !== 5'd0)    begin n_bad++; $display("FAIL clr_level got=%0d want=0", o_level); end
    n_total++; if (o_row_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%b want=0", o_row_valid); end
    for (int i = 0; i < 6; i++) step(1, 32'h200 + DW'(i), 1, 0, 0);
    n_total++; if (o_partial !== 1'b1) begin n_bad++; $display("FAIL clr_partial_pre got=%b want=1", o_partial); end
    step(1, 32'hDEAD, 1, 1, 0);
    n_total++; if (o_partial !== 1'b0) begin n_bad++; $display("FAIL clr_partial_post got=%b want=0", o_partial); end
    n_total++; if (o_level !== 5'd0)   begin n_bad++; $display("FAIL clr_level_post got=%0d want=0", o_level); end
    n_total++; if (o_row_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid_post got=%b want=0", o_row_valid); end
    rx_rows.delete();
    for (int i = 0; i < 4; i++) step(1, 32'h300 + DW'(i), 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    n_total++; if (rx_rows.size() != 1) begin n_bad++; $display("FAIL clr_fresh_count got=%0d want=1", rx_rows.size()); end
    if (rx_rows.size() >= 1) begin
      n_total++; if (rx_rows[0] !== pack(32'h300)) begin n_bad++; $display("FAIL clr_fresh_row got=%h want=%h", rx_rows[0], pack(32'h300)); end
    end
  endtask

  task automatic test_full_release();
    step(0, 0, 0, 1, 0);
    rx_rows.delete();
    for (int i = 0; i < 23; i++) step(1, 32'h400 + DW'(i), 0, 0, 0);
    n_total++; if (o_level !== 5'd16) begin n_bad++; $display("FAIL rel_level_pre got=%0d want=16", o_level); end
    n_total++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rel_ovf_pre got=%b want=0", o_overflow); end
    step(1, 32'h4FF, 1, 0, 0);
    n_total++; if (o_level !== 5'd16) begin n_bad++; $display("FAIL rel_level got=%0d want=16", o_level); end
    n_total++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rel_ovf got=%b want=0", o_overflow); end
    n_total++; if (o_row_valid !== 1'b1) begin n_bad++; $display("FAIL rel_valid got=%b want=1", o_row_valid); end
    n_total++; if (o_row !== pack(32'h404)) begin n_bad++; $display("FAIL rel_b2b_row got=%h want=%h", o_row, pack(32'h404)); end
    n_total++; if (rx_rows.size() != 1) begin n_bad++; $display("FAIL rel_rx_count got=%0d want=1", rx_rows.size()); end
    if (rx_rows.size() >= 1) begin
      n_total++; if (rx_rows[0] !== pack(32'h400)) begin n_bad++; $display("FAIL rel_rx0 got=%h want=%h", rx_rows[0], pack(32'h400)); end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h500 + DW'(i), 1, 0, 0);
    step(1, 32'h5FF, 1, 0, 1);
    n_total++; if (o_row !== '0)         begin n_bad++; $display("FAIL rst_mid_row got=%h want=0", o_row); end
    n_total++; if (o_row_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got=%b want=0", o_row_valid); end
    n_total++; if (o_level !== 5'd0)     begin n_bad++; $display("FAIL rst_mid_level got=%0d want=0", o_level); end
    n_total++; if (o_overflow !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_ovf got=%b want=0", o_overflow); end
    n_total++; if (o_partial !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_partial got=%b want=0", o_partial); end
    rx_rows.delete();
    for (int i = 0; i < 4; i++) step(1, 32'h600 + DW'(i), 1, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    n_total++; if (rx_rows.size() != 1) begin n_bad++; $display("FAIL rst_mid_count got=%0d want=1", rx_rows.size()); end
    if (rx_rows.size() >= 1) begin
      n_total++; if (rx_rows[0] !== pack(32'h600)) begin n_bad++; $display("FAIL rst_mid_row1 got=%h want=%h", rx_rows[0], pack(32'h600)); end
    end
    n_total++; if (o_partial !== 1'b0) begin n_bad++; $display("FAIL rst_mid_partial_end got=%b want=0", o_partial); end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    logic [RW*DW-1:0] exp_row;
    logic v, r;
    logic [DW-1:0] d;
    int cyc;
    step(0, 0, 1, 1, 0);
    rx_rows.delete();
    cyc = 0;
    while ((sent.size() < 64 || rx_rows.size() < 16) && cyc < 2000) begin
      v = (sent.size() < 64) && ($urandom_range(0, 3) != 0);
      d = $urandom;
      r = 1'($urandom_range(0, 1));
      step(v, d, r, 0, 0);
      if (v) sent.push_back(d);
      cyc++;
      n_total++; if (o_level !== 5'(m_fifo.size())) begin n_bad++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", cyc, o_level, m_fifo.size()); end
      n_total++; if (o_row_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, o_row_valid, m_valid); end
      n_total++; if (o_partial !== (m_asm.size() != 0)) begin n_bad++; $display("FAIL rnd_partial cyc=%0d got=%b want=%b", cyc, o_partial, m_asm.size() != 0); end
      if (m_valid) begin
        n_total++; if (o_row !== m_row) begin n_bad++; $display("FAIL rnd_row cyc=%0d got=%h want=%h", cyc, o_row, m_row); end
      end
    end
    n_total++; if (rx_rows.size() != 16) begin n_bad++; $display("FAIL rnd_row_count got=%0d want=16", rx_rows.size()); end
    n_total++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rnd_ovf got=%b want=0", o_overflow); end
    for (int i = 0; i < 16 && i < rx_rows.size() && 4*i+3 < sent.size(); i++) begin
      exp_row = {sent[4*i+3], sent[4*i+2], sent[4*i+1], sent[4*i]};
      n_total++; if (rx_rows[i] !== exp_row) begin n_bad++; $display("FAIL rnd_rx%0d got=%h want=%h", i, rx_rows[i], exp_row); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_clear();
    test_full_release();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
